// File: rtl/tile_draw_sequencer.sv
// ============================================================================
// Module  : tile_draw_sequencer
// Purpose : Boot-draws every tile, or flashes one tile (flash draw, hold, restore),
//           generating the in-tile pixel raster for the VGA write port.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tile_draw_sequencer #(
  parameter int NUM_TILES    = 4,
  parameter int IDX_W        = 2,
  parameter int TILE_W       = 16,
  parameter int TILE_H       = 16,
  parameter int XW           = 4,
  parameter int YW           = 4,
  parameter int FLASH_CYCLES = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             boot_start,
  input  logic             flash_req,
  input  logic [IDX_W-1:0] flash_tile,
  output logic             ready,
  output logic             writeEnable,
  output logic [IDX_W-1:0] tile_num,
  output logic             colour_sel,
  output logic [XW-1:0]    px_x,
  output logic [YW-1:0]    px_y,
  output logic             done,
  output logic             req_err
);

  localparam int HW = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;

  localparam logic [IDX_W:0]   c_NUM_TILES = (IDX_W + 1)'(NUM_TILES);
  localparam logic [IDX_W-1:0] c_TILE_LAST = IDX_W'(NUM_TILES - 1);
  localparam logic [XW-1:0]    c_X_LAST    = XW'(TILE_W - 1);
  localparam logic [YW-1:0]    c_Y_LAST    = YW'(TILE_H - 1);
  localparam logic [HW-1:0]    c_HOLD_LAST = HW'(FLASH_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_BOOT_DRAW    = 3'd1,
    S_FLASH_DRAW   = 3'd2,
    S_FLASH_HOLD   = 3'd3,
    S_RESTORE_DRAW = 3'd4,
    S_DONE         = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [IDX_W-1:0] r_tile;
  logic [XW-1:0]    r_px_x;
  logic [YW-1:0]    r_px_y;
  logic [HW-1:0]    r_hold;
  logic             r_req_err;
  logic             w_last_px;
  logic             w_flash_ok;
  logic             w_drawing;

  assign tile_num = r_tile;
  assign px_x     = r_px_x;
  assign px_y     = r_px_y;
  assign req_err  = r_req_err;

  always_comb begin
    w_last_px    = (r_px_x == c_X_LAST) && (r_px_y == c_Y_LAST);
    w_flash_ok   = ({1'b0, flash_tile} < c_NUM_TILES);
    w_drawing    = 1'b0;
    w_next_state = r_state;
    ready        = 1'b0;
    writeEnable  = 1'b0;
    colour_sel   = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready = 1'b1;
        // boot wins over a simultaneous flash request
        if (boot_start) begin
          w_next_state = S_BOOT_DRAW;
        end else if (flash_req && w_flash_ok) begin
          w_next_state = S_FLASH_DRAW;
        end
      end
      S_BOOT_DRAW: begin
        w_drawing   = 1'b1;
        writeEnable = 1'b1;
        if (w_last_px && (r_tile == c_TILE_LAST)) begin
          w_next_state = S_DONE;
        end
      end
      S_FLASH_DRAW: begin
        w_drawing   = 1'b1;
        writeEnable = 1'b1;
        colour_sel  = 1'b1;
        if (w_last_px) begin
          w_next_state = S_FLASH_HOLD;
        end
      end
      S_FLASH_HOLD: begin
        colour_sel = 1'b1;
        if (r_hold == c_HOLD_LAST) begin
          w_next_state = S_RESTORE_DRAW;
        end
      end
      S_RESTORE_DRAW: begin
        w_drawing   = 1'b1;
        writeEnable = 1'b1;
        if (w_last_px) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        done         = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_tile    <= '0;
      r_px_x    <= '0;
      r_px_y    <= '0;
      r_hold    <= '0;
      r_req_err <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_req_err <= (r_state == S_IDLE) && !boot_start && flash_req && !w_flash_ok;

      // raster counters run only while drawing and rest at zero otherwise
      if (w_drawing) begin
        if (r_px_x == c_X_LAST) begin
          r_px_x <= '0;
          r_px_y <= (r_px_y == c_Y_LAST) ? '0 : r_px_y + YW'(1);
        end else begin
          r_px_x <= r_px_x + XW'(1);
        end
      end else begin
        r_px_x <= '0;
        r_px_y <= '0;
      end

      if (r_state == S_IDLE) begin
        if (boot_start) begin
          r_tile <= '0;
        end else if (flash_req && w_flash_ok) begin
          r_tile <= flash_tile;
        end
      end else if ((r_state == S_BOOT_DRAW) && w_last_px && (r_tile != c_TILE_LAST)) begin
        r_tile <= r_tile + IDX_W'(1);
      end

      r_hold <= (r_state == S_FLASH_HOLD) ? r_hold + HW'(1) : '0;
    end
  end

endmodule

`default_nettype wire
